uart_mem_bridge: RTL and testbench

UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

---
 rtl/uart_mem_pkg.sv | 30 +++
 rtl/uart_tx_serializer.sv | 57 +++++
 rtl/uart_mem_bridge.sv | 191 +++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART-to-memory bridge: FSM states, reply bytes,
// header bit positions and the layout of the memory read response.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        DATA      = 3'd2,
        WAIT_HALT = 3'd3,
        ISSUE     = 3'd4,
        WAIT_RESP = 3'd5,
        SEND      = 3'd6
    } state_e;

    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam int HDR_RW_BIT    = 7;
    localparam int HDR_TYPE_BIT  = 6;
    localparam int HDR_ADDR8_BIT = 0;

    // Response is {1'b0, addr[8:0], data[31:0]}; the reply frame is six bytes, MSB first.
    localparam int RESP_W  = 42;
    localparam int FRAME_W = 48;

    function automatic logic [FRAME_W-1:0] resp_frame(input logic [RESP_W-1:0] resp);
        return {6'b000000, resp[41:40], resp[39:32], resp[31:24], resp[23:16], resp[15:8], resp[7:0]};
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds up to six reply bytes and hands them to the UART transmitter one at a
// time under valid/ready flow control; the byte on tx_byte never changes while stalled.
module uart_tx_serializer
    import uart_mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_bytes,
    input  logic [2:0]         load_count,
    input  logic               tx_ready,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    output logic               last
);

    logic [FRAME_W-1:0] buf_q, buf_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               fire_s;

    assign fire_s   = valid_q && tx_ready;
    assign last     = fire_s && (cnt_q == 3'd1);
    assign tx_byte  = buf_q[FRAME_W-1 -: 8];
    assign tx_valid = valid_q;

    // Next-state for the shift buffer and remaining-byte count
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (load) begin
            buf_d = load_bytes;
            cnt_d = load_count;
        end else if (fire_s) begin
            buf_d = {buf_q[FRAME_W-9:0], 8'h00};
            cnt_d = cnt_q - 3'd1;
        end else begin
            buf_d = buf_q;
            cnt_d = cnt_q;
        end
        valid_d = (cnt_d != 3'd0);
    end

    // Buffer, count and valid registers
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q   <= '0;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command bridge into CPU memory: parses header/address/data frames, waits for
// the CPU to halt, issues one access and replies. Define UART_MEM_BRIDGE_TIMEOUT_EN for a read timeout.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              cpu_enable,
    output logic              write_mem_req,
    output logic              target_mem_type,
    output logic [8:0]        target_addr,
    output logic [31:0]       uart_rx_data_in,
    output logic              rw_flag,
    input  logic [RESP_W-1:0] mem_tx_data,
    input  logic              mem_tx_data_ready,
    output logic              busy
);

    state_e             state_q, state_d;
    logic               rw_q, rw_d, type_q, type_d;
    logic               req_q, req_d, busy_q, busy_d;
    logic [8:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               ser_load_s, ser_last_s, tmo_hit_s;
    logic [FRAME_W-1:0] ser_bytes_s;
    logic [2:0]         ser_count_s;

`ifdef UART_MEM_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Cycles spent in WAIT_RESP; cleared whenever the FSM is elsewhere
    always_comb begin
        if (state_q == WAIT_RESP) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end
    end

    assign tmo_hit_s = (state_q == WAIT_RESP) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Timeout counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Frame parser and access sequencer; rx bytes only matter in IDLE/ADDR/DATA
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        type_d      = type_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        req_d       = 1'b0;
        ser_load_s  = 1'b0;
        ser_bytes_s = '0;
        ser_count_s = 3'd0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    rw_d    = rx_byte[HDR_RW_BIT];
                    type_d  = rx_byte[HDR_TYPE_BIT];
                    addr_d  = {rx_byte[HDR_ADDR8_BIT], 8'h00};
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    addr_d  = {addr_q[8], rx_byte};
                    cnt_d   = 2'd0;
                    state_d = rw_q ? DATA : WAIT_HALT;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    data_d  = {data_q[23:0], rx_byte};
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd3) ? WAIT_HALT : DATA;
                end else begin
                    state_d = DATA;
                end
            end
            WAIT_HALT: begin
                if (!cpu_enable) begin
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = WAIT_HALT;
                end
            end
            ISSUE: begin
                if (rw_q) begin
                    ser_load_s  = 1'b1;
                    ser_bytes_s = {ACK_BYTE, 40'd0};
                    ser_count_s = 3'd1;
                    state_d     = SEND;
                end else begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_tx_data_ready) begin
                    ser_load_s  = 1'b1;
                    ser_bytes_s = resp_frame(mem_tx_data);
                    ser_count_s = 3'd6;
                    state_d     = SEND;
                end else if (tmo_hit_s) begin
                    ser_load_s  = 1'b1;
                    ser_bytes_s = {ERR_BYTE, 40'd0};
                    ser_count_s = 3'd1;
                    state_d     = SEND;
                end else begin
                    state_d = WAIT_RESP;
                end
            end
            SEND: begin
                if (ser_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            type_q  <= 1'b0;
            addr_q  <= 9'd0;
            data_q  <= 32'd0;
            cnt_q   <= 2'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    uart_tx_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .load       (ser_load_s),
        .load_bytes (ser_bytes_s),
        .load_count (ser_count_s),
        .tx_ready   (tx_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .last       (ser_last_s)
    );

    assign write_mem_req   = req_q;
    assign target_mem_type = type_q;
    assign target_addr     = addr_q;
    assign uart_rx_data_in = data_q;
    assign rw_flag         = rw_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed self-checking bench for uart_mem_bridge (TIMEOUT_CYCLES=8); the timeout
// scenario is selected by UART_MEM_BRIDGE_TIMEOUT_EN, otherwise an endless wait is checked.
module tb_uart_mem_bridge;

    logic        clk = 1'b0;
    logic        reset, rx_valid, tx_valid, tx_ready, cpu_enable;
    logic        write_mem_req, target_mem_type, rw_flag, mem_tx_data_ready, busy;
    logic [7:0]  rx_byte, tx_byte;
    logic [8:0]  target_addr;
    logic [31:0] uart_rx_data_in;
    logic [41:0] mem_tx_data;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  tx_q[$];
    int          req_cnt;
    logic [8:0]  cap_addr;
    logic        cap_type, cap_rw;
    logic [31:0] cap_data;

    always #5 clk = ~clk;

    uart_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_byte           (rx_byte),
        .rx_valid          (rx_valid),
        .tx_byte           (tx_byte),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .cpu_enable        (cpu_enable),
        .write_mem_req     (write_mem_req),
        .target_mem_type   (target_mem_type),
        .target_addr       (target_addr),
        .uart_rx_data_in   (uart_rx_data_in),
        .rw_flag           (rw_flag),
        .mem_tx_data       (mem_tx_data),
        .mem_tx_data_ready (mem_tx_data_ready),
        .busy              (busy)
    );

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        tx_q.delete();
        req_cnt = 0;
    endtask

    // Observe n cycles: log request pulses with their fields and every accepted tx byte
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (write_mem_req) begin
                req_cnt++;
                cap_addr = target_addr;
                cap_type = target_mem_type;
                cap_rw   = rw_flag;
                cap_data = uart_rx_data_in;
            end
            if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({write_mem_req, tx_valid, busy, rw_flag, target_mem_type} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000", {write_mem_req, tx_valid, busy, rw_flag, target_mem_type});
        end
        checks++;
        if ({target_addr, uart_rx_data_in, tx_byte} !== 49'd0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h data=%h tx=%h want all zero", target_addr, uart_rx_data_in, tx_byte);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        clear_log();
        cpu_enable = 1'b0;
        send_byte(8'h81); send_byte(8'h05);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        collect(8);
        checks++;
        if (req_cnt !== 1) begin fails++; $display("FAIL write_req_count: got %0d want 1", req_cnt); end
        checks++;
        if ({cap_rw, cap_type, cap_addr, cap_data} !== {1'b1, 1'b0, 9'h105, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL write_fields: got rw=%b type=%b addr=%h data=%h want 1 0 105 deadbeef", cap_rw, cap_type, cap_addr, cap_data);
        end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'hA5) begin
            fails++;
            $display("FAIL write_ack: got %0d bytes first=%h want 1 byte a5", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
        end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL write_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_read();
        logic [7:0] exp[6] = '{8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78};
        logic [7:0] got;
        clear_log();
        cpu_enable = 1'b0;
        send_byte(8'h00); send_byte(8'h10);
        @(posedge clk); #1;
        checks++;
        if ({write_mem_req, rw_flag, target_mem_type, target_addr} !== {1'b1, 1'b0, 1'b0, 9'h010}) begin
            fails++;
            $display("FAIL read_issue: got req=%b rw=%b type=%b addr=%h want 1 0 0 010", write_mem_req, rw_flag, target_mem_type, target_addr);
        end
        // A response strobe during ISSUE must be ignored
        mem_tx_data = {1'b0, 9'h1FF, 32'hFFFFFFFF};
        mem_tx_data_ready = 1'b1;
        @(posedge clk); #1;
        mem_tx_data = {1'b0, 9'h010, 32'h12345678};
        @(posedge clk); #1;
        mem_tx_data_ready = 1'b0;
        collect(10);
        checks++;
        if (tx_q.size() !== 6) begin fails++; $display("FAIL read_len: got %0d want 6", tx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'h00;
            checks++;
            if (i >= tx_q.size() || got !== exp[i]) begin
                fails++;
                $display("FAIL read_byte%0d: got %h want %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_halt_wait();
        clear_log();
        cpu_enable = 1'b1;
        send_byte(8'h80); send_byte(8'h33);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        collect(10);
        send_byte(8'h81);
        collect(9);
        checks++;
        if (req_cnt !== 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL halt_hold: got req_cnt=%0d busy=%b want 0 1", req_cnt, busy);
        end
        cpu_enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (write_mem_req !== 1'b1) begin fails++; $display("FAIL halt_release: req=%b want 1", write_mem_req); end
        collect(6);
        checks++;
        if (req_cnt !== 1 || cap_data !== 32'h01020304 || cap_addr !== 9'h033) begin
            fails++;
            $display("FAIL halt_access: got req_cnt=%0d data=%h addr=%h want 1 01020304 033", req_cnt, cap_data, cap_addr);
        end
        checks++;
        if (tx_q.size() !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL halt_ack: got %0d bytes busy=%b want 1 byte busy 0", tx_q.size(), busy);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp[6] = '{8'h01, 8'h23, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        logic [7:0] got;
        int held_bad;
        clear_log();
        held_bad = 0;
        cpu_enable = 1'b0;
        tx_ready = 1'b0;
        send_byte(8'h41); send_byte(8'h23);
        @(posedge clk); #1;
        checks++;
        if ({write_mem_req, target_mem_type, target_addr} !== {1'b1, 1'b1, 9'h123}) begin
            fails++;
            $display("FAIL bp_issue: got req=%b type=%b addr=%h want 1 1 123", write_mem_req, target_mem_type, target_addr);
        end
        @(posedge clk); #1;
        mem_tx_data = {1'b0, 9'h123, 32'hCAFEF00D};
        mem_tx_data_ready = 1'b1;
        @(posedge clk); #1;
        mem_tx_data_ready = 1'b0;
        tx_ready = 1'b1;
        collect(2);
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid !== 1'b1 || tx_byte !== 8'hCA) held_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (held_bad !== 0) begin fails++; $display("FAIL bp_hold: %0d stalled cycles lost byte ca (got %h)", held_bad, tx_byte); end
        tx_ready = 1'b1;
        collect(10);
        checks++;
        if (tx_q.size() !== 6) begin fails++; $display("FAIL bp_len: got %0d want 6", tx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'h00;
            checks++;
            if (i >= tx_q.size() || got !== exp[i]) begin
                fails++;
                $display("FAIL bp_byte%0d: got %h want %h", i, got, exp[i]);
            end
        end
    endtask

`ifdef UART_MEM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        cpu_enable = 1'b0;
        tx_ready = 1'b1;
        send_byte(8'h00); send_byte(8'h20);
        @(posedge clk); #1;
        k = 0;
        while (tx_valid !== 1'b1 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k !== 9 || tx_byte !== 8'hEE) begin
            fails++;
            $display("FAIL timeout_err: got tx at %0d cycles after req byte %h want 9 ee", k, tx_byte);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: busy=%b tx_valid=%b want 0 0", busy, tx_valid);
        end
    endtask
`else
    task automatic test_no_timeout();
        int seen;
        clear_log();
        seen = 0;
        cpu_enable = 1'b0;
        tx_ready = 1'b1;
        send_byte(8'h00); send_byte(8'h20);
        for (int i = 0; i < 30; i++) begin
            if (tx_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL wait_forever: tx cycles=%0d busy=%b want 0 1", seen, busy);
        end
        mem_tx_data = {1'b0, 9'h020, 32'h0000BEEF};
        mem_tx_data_ready = 1'b1;
        @(posedge clk); #1;
        mem_tx_data_ready = 1'b0;
        collect(10);
        checks++;
        if (tx_q.size() !== 6 || tx_q[5] !== 8'hEF) begin
            fails++;
            $display("FAIL late_resp: got %0d bytes want 6 ending ef", tx_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid_data();
        clear_log();
        cpu_enable = 1'b0;
        tx_ready = 1'b1;
        send_byte(8'h81); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({write_mem_req, tx_valid, busy, rw_flag, target_mem_type, target_addr, uart_rx_data_in, tx_byte} !== 54'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: req=%b txv=%b busy=%b rw=%b type=%b addr=%h data=%h tx=%h want all zero",
                     write_mem_req, tx_valid, busy, rw_flag, target_mem_type, target_addr, uart_rx_data_in, tx_byte);
        end
        collect(5);
        checks++;
        if (req_cnt !== 0 || tx_q.size() !== 0) begin
            fails++;
            $display("FAIL rst_mid_quiet: got req_cnt=%0d tx=%0d want 0 0", req_cnt, tx_q.size());
        end
        send_byte(8'hC0); send_byte(8'h7E);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        collect(8);
        checks++;
        if (req_cnt !== 1 || {cap_rw, cap_type, cap_addr, cap_data} !== {1'b1, 1'b1, 9'h07E, 32'h11223344}) begin
            fails++;
            $display("FAIL rst_next_frame: got cnt=%0d rw=%b type=%b addr=%h data=%h want 1 1 1 07e 11223344",
                     req_cnt, cap_rw, cap_type, cap_addr, cap_data);
        end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'hA5) begin
            fails++;
            $display("FAIL rst_next_ack: got %0d bytes want 1 byte a5", tx_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rx_byte = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        cpu_enable = 1'b0;
        mem_tx_data = 42'd0;
        mem_tx_data_ready = 1'b0;
        req_cnt = 0;
        test_reset();
        test_write();
        test_read();
        test_halt_wait();
        test_back_pressure();
`ifdef UART_MEM_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
